// File: rtl/mmss_timer_display.sv
// mmss_timer_display
//   Minutes:seconds timer (00:00 .. MAX_MIN:59) driving four 7-segment digits.
//   A prescaler produces a one-cycle count step every TICK_DIV clocks. Digits
//   count up (with wrap) or down (halting at 00:00). They accept a validated
//   BCD preset, and report tick/wrap/done/load_err as one-cycle pulses.
//
// Ports
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   run       in   1 = count, 0 = pause (prescaler holds its value)
//   up_down   in   1 = count up, 0 = count down
//   load      in   synchronous preset strobe
//   load_bcd  in   preset {m_tens, m_units, s_tens, s_units}
//   bcd_out   out  current value, same packing as load_bcd
//   seg       out  {m_tens, m_units, s_tens, s_units} x {g,f,e,d,c,b,a}, active-low
//   tick      out  pulse on every count step
//   wrap      out  pulse on MAX_MIN:59 -> 00:00 while counting up
//   done      out  pulse when a down step reaches (or sits at) 00:00
//   load_err  out  pulse when a preset is rejected
module mmss_timer_display #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned MAX_MIN  = 59,
    parameter bit          BLANK_LZ = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        up_down,
    input  logic        load,
    input  logic [15:0] load_bcd,
    output logic [15:0] bcd_out,
    output logic [27:0] seg,
    output logic        tick,
    output logic        wrap,
    output logic        done,
    output logic        load_err
);

    localparam int unsigned   PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]    MAX_M      = 8'(MAX_MIN);

    typedef enum logic {ST_COUNT, ST_HALT} state_t;

    state_t        state, state_next;
    logic [PW-1:0] presc;
    logic [3:0]    m_tens, m_units, s_tens, s_units;
    logic [3:0]    n_mt, n_mu, n_st, n_su;
    logic [7:0]    ld_min, cur_min;
    logic          load_ok, step, at_max, at_zero, one_sec;
    logic          step_wrap, step_done;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h40;
            4'd1:    p = 7'h79;
            4'd2:    p = 7'h24;
            4'd3:    p = 7'h30;
            4'd4:    p = 7'h19;
            4'd5:    p = 7'h12;
            4'd6:    p = 7'h02;
            4'd7:    p = 7'h78;
            4'd8:    p = 7'h00;
            4'd9:    p = 7'h10;
            default: p = 7'h7F;
        endcase
        return p;
    endfunction

    // Preset validation and terminal-value detection
    always_comb begin
        ld_min  = ({4'd0, load_bcd[15:12]} << 3) + ({4'd0, load_bcd[15:12]} << 1)
                + {4'd0, load_bcd[11:8]};
        cur_min = ({4'd0, m_tens} << 3) + ({4'd0, m_tens} << 1) + {4'd0, m_units};
        load_ok = (load_bcd[15:12] <= 4'd9) && (load_bcd[11:8] <= 4'd9)
               && (load_bcd[7:4] <= 4'd5)   && (load_bcd[3:0] <= 4'd9)
               && (ld_min <= MAX_M);
        at_max  = (cur_min == MAX_M) && (s_tens == 4'd5) && (s_units == 4'd9);
        at_zero = (m_tens == 4'd0) && (m_units == 4'd0) && (s_tens == 4'd0) && (s_units == 4'd0);
        one_sec = (m_tens == 4'd0) && (m_units == 4'd0) && (s_tens == 4'd0) && (s_units == 4'd1);
        // load pre-empts a coincident step, accepted or not
        step    = (state == ST_COUNT) && run && (presc == PRESC_LAST) && !load;
    end

    // Next digit values for one count step in the current direction
    always_comb begin
        n_mt      = m_tens;
        n_mu      = m_units;
        n_st      = s_tens;
        n_su      = s_units;
        step_wrap = 1'b0;
        step_done = 1'b0;
        if (up_down) begin
            if (at_max) begin
                n_mt      = '0;
                n_mu      = '0;
                n_st      = '0;
                n_su      = '0;
                step_wrap = 1'b1;
            end else if (s_units != 4'd9) begin
                n_su = s_units + 4'd1;
            end else begin
                n_su = '0;
                if (s_tens != 4'd5) begin
                    n_st = s_tens + 4'd1;
                end else begin
                    n_st = '0;
                    if (m_units != 4'd9) begin
                        n_mu = m_units + 4'd1;
                    end else begin
                        n_mu = '0;
                        n_mt = m_tens + 4'd1;
                    end
                end
            end
        end else begin
            step_done = at_zero || one_sec;
            if (!at_zero) begin
                if (s_units != 4'd0) begin
                    n_su = s_units - 4'd1;
                end else begin
                    n_su = 4'd9;
                    if (s_tens != 4'd0) begin
                        n_st = s_tens - 4'd1;
                    end else begin
                        n_st = 4'd5;
                        if (m_units != 4'd0) begin
                            n_mu = m_units - 4'd1;
                        end else begin
                            n_mu = 4'd9;
                            n_mt = m_tens - 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Run/halt control: halting happens on a done step, release only via accepted load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_COUNT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_COUNT: if (step && step_done)  state_next = ST_HALT;
            ST_HALT:  if (load && load_ok)    state_next = ST_COUNT;
            default:  state_next = ST_COUNT;
        endcase
    end

    // Prescaler, digit registers and event pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc    <= '0;
            m_tens   <= '0;
            m_units  <= '0;
            s_tens   <= '0;
            s_units  <= '0;
            tick     <= 1'b0;
            wrap     <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tick     <= 1'b0;
            wrap     <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    presc   <= '0;
                    m_tens  <= load_bcd[15:12];
                    m_units <= load_bcd[11:8];
                    s_tens  <= load_bcd[7:4];
                    s_units <= load_bcd[3:0];
                end else begin
                    load_err <= 1'b1;
                end
            end else if (step) begin
                presc   <= '0;
                m_tens  <= n_mt;
                m_units <= n_mu;
                s_tens  <= n_st;
                s_units <= n_su;
                tick    <= 1'b1;
                wrap    <= step_wrap;
                done    <= step_done;
            end else if (state == ST_COUNT && run) begin
                presc <= presc + PW'(1);
            end
        end
    end

    always_comb begin
        bcd_out       = {m_tens, m_units, s_tens, s_units};
        seg[27:21]    = (BLANK_LZ && m_tens == 4'd0) ? 7'h7F : seg7(m_tens);
        seg[20:14]    = seg7(m_units);
        seg[13:7]     = seg7(s_tens);
        seg[6:0]      = seg7(s_units);
    end

endmodule

// File: tb/tb_mmss_timer_display.sv
module tb_mmss_timer_display;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, run;
    logic        a_up, a_load, b_up, b_load;
    logic [15:0] a_ld, b_ld;
    logic [15:0] a_bcd, b_bcd;
    logic [27:0] a_seg, b_seg;
    logic        a_tick, a_wrap, a_done, a_err;
    logic        b_tick, b_wrap, b_done, b_err;

    // A: short range with minute-tens blanking; B: full range, no blanking
    mmss_timer_display #(.TICK_DIV(4), .MAX_MIN(2), .BLANK_LZ(1'b1)) dut_a (
        .clk(clk), .reset(rst_n), .run(run), .up_down(a_up), .load(a_load),
        .load_bcd(a_ld), .bcd_out(a_bcd), .seg(a_seg), .tick(a_tick),
        .wrap(a_wrap), .done(a_done), .load_err(a_err));

    mmss_timer_display #(.TICK_DIV(4), .MAX_MIN(59), .BLANK_LZ(1'b0)) dut_b (
        .clk(clk), .reset(rst_n), .run(run), .up_down(b_up), .load(b_load),
        .load_bcd(b_ld), .bcd_out(b_bcd), .seg(b_seg), .tick(b_tick),
        .wrap(b_wrap), .done(b_done), .load_err(b_err));

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    typedef struct {
        bit          sel;       // 0 = dut_a, 1 = dut_b
        bit          ld;        // 1 = apply preset, 0 = wait for next step
        logic [15:0] val;
        bit          up;
        logic [15:0] exp_bcd;
        bit          exp_wrap;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    // Segment patterns written active-high as {g,f,e,d,c,b,a}, inverted for the display
    function automatic logic [6:0] pat(input logic [3:0] d);
        logic [6:0] ah;
        case (d)
            4'd0: ah = 7'b0111111;
            4'd1: ah = 7'b0000110;
            4'd2: ah = 7'b1011011;
            4'd3: ah = 7'b1001111;
            4'd4: ah = 7'b1100110;
            4'd5: ah = 7'b1101101;
            4'd6: ah = 7'b1111101;
            4'd7: ah = 7'b0000111;
            4'd8: ah = 7'b1111111;
            4'd9: ah = 7'b1101111;
            default: ah = 7'b0000000;
        endcase
        return ~ah;
    endfunction

    function automatic logic [27:0] exp_seg(input logic [15:0] b, input bit blank);
        logic [6:0] mt;
        mt = (blank && b[15:12] == 4'd0) ? 7'b1111111 : pat(b[15:12]);
        return {mt, pat(b[11:8]), pat(b[7:4]), pat(b[3:0])};
    endfunction

    function automatic logic [15:0] to_bcd(input int unsigned secs);
        int unsigned m, s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    // Advance until the selected DUT reports tick/wrap/done; returns edges taken
    task automatic wait_evt(input bit sel, output int unsigned n);
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            tick_clk();
            n++;
            seen = sel ? (b_tick | b_wrap | b_done) : (a_tick | a_wrap | a_done);
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_evt dut%0d: no step within %0d cycles", sel, n);
        end
    endtask

    task automatic add(input bit sel, input bit ld, input logic [15:0] val, input bit up,
                       input logic [15:0] e, input bit w, input bit d, input bit er);
        vec_t v;
        v.sel = sel; v.ld = ld; v.val = val; v.up = up;
        v.exp_bcd = e; v.exp_wrap = w; v.exp_done = d; v.exp_err = er;
        vecs.push_back(v);
    endtask

    task automatic load_a(input logic [15:0] val);
        a_load = 1'b1;
        a_ld   = val;
        tick_clk();
        a_load = 1'b0;
    endtask

    initial begin
        int unsigned n;
        bit          any;
        vec_t        e;
        logic [15:0] g_bcd;
        logic [27:0] g_seg;
        logic        g_tick, g_wrap, g_done, g_err;

        rst_n = 1'b1; run = 1'b1;
        a_up = 1'b1; a_load = 1'b0; a_ld = '0;
        b_up = 1'b1; b_load = 1'b0; b_ld = '0;

        // Async reset state, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst a_bcd", 32'(a_bcd), 32'h0000);
        chk("rst a_seg", 32'(a_seg), 32'(exp_seg(16'h0000, 1'b1)));
        chk("rst a_flags", 32'({a_tick, a_wrap, a_done, a_err}), 32'h0);
        chk("rst b_seg", 32'(b_seg), 32'(exp_seg(16'h0000, 1'b0)));

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Count up 60 steps from reset; every step is 4 clocks
        for (int unsigned i = 1; i <= 60; i++) begin
            wait_evt(1'b0, n);
            chk($sformatf("up%0d gap", i), 32'(n), 32'd4);
            chk($sformatf("up%0d bcd", i), 32'(a_bcd), 32'(to_bcd(i)));
        end
        chk("up60 seg_sec", 32'(a_seg[13:0]), 32'({pat(4'd0), pat(4'd0)}));
        chk("up60 seg", 32'(a_seg), 32'(exp_seg(16'h0100, 1'b1)));

        // Pause mid-prescale: remaining phase is kept
        tick_clk();
        tick_clk();
        run = 1'b0;
        any = 1'b0;
        repeat (10) begin
            tick_clk();
            any |= a_tick;
        end
        chk("pause tick", 32'(any), 32'd0);
        chk("pause bcd", 32'(a_bcd), 32'h0100);
        run = 1'b1;
        wait_evt(1'b0, n);
        chk("resume gap", 32'(n), 32'd2);
        chk("resume bcd", 32'(a_bcd), 32'h0101);

        // Vector table
        add(0, 1, 16'h0259, 1, 16'h0259, 0, 0, 0);
        add(0, 0, 16'h0000, 1, 16'h0000, 1, 0, 0);
        add(0, 0, 16'h0000, 1, 16'h0001, 0, 0, 0);
        add(0, 1, 16'h0070, 1, 16'h0001, 0, 0, 1);
        add(0, 1, 16'h6000, 1, 16'h0001, 0, 0, 1);
        add(0, 1, 16'h0300, 1, 16'h0001, 0, 0, 1);
        add(0, 1, 16'h000A, 1, 16'h0001, 0, 0, 1);
        add(0, 1, 16'h0159, 1, 16'h0159, 0, 0, 0);
        add(0, 0, 16'h0000, 1, 16'h0200, 0, 0, 0);
        add(0, 1, 16'h0100, 0, 16'h0100, 0, 0, 0);
        add(0, 0, 16'h0000, 0, 16'h0059, 0, 0, 0);
        add(0, 1, 16'h0210, 0, 16'h0210, 0, 0, 0);
        add(0, 0, 16'h0000, 0, 16'h0209, 0, 0, 0);
        add(0, 1, 16'h0200, 0, 16'h0200, 0, 0, 0);
        add(0, 0, 16'h0000, 0, 16'h0159, 0, 0, 0);
        add(1, 1, 16'h1259, 1, 16'h1259, 0, 0, 0);
        add(1, 1, 16'h6000, 1, 16'h1259, 0, 0, 1);
        add(1, 0, 16'h0000, 1, 16'h1300, 0, 0, 0);
        add(1, 1, 16'h5959, 1, 16'h5959, 0, 0, 0);
        add(1, 0, 16'h0000, 1, 16'h0000, 1, 0, 0);
        add(1, 1, 16'h4000, 0, 16'h4000, 0, 0, 0);
        add(1, 0, 16'h0000, 0, 16'h3959, 0, 0, 0);
        add(1, 1, 16'h0959, 1, 16'h0959, 0, 0, 0);
        add(1, 0, 16'h0000, 1, 16'h1000, 0, 0, 0);

        for (int unsigned i = 0; i < vecs.size(); i++) begin
            sb.push_back(vecs[i]);
            if (vecs[i].sel) b_up = vecs[i].up;
            else             a_up = vecs[i].up;
            if (vecs[i].ld) begin
                if (vecs[i].sel) begin b_load = 1'b1; b_ld = vecs[i].val; end
                else             begin a_load = 1'b1; a_ld = vecs[i].val; end
                tick_clk();
                a_load = 1'b0;
                b_load = 1'b0;
            end else begin
                wait_evt(vecs[i].sel, n);
            end
            e = sb.pop_front();
            g_bcd  = e.sel ? b_bcd  : a_bcd;
            g_seg  = e.sel ? b_seg  : a_seg;
            g_tick = e.sel ? b_tick : a_tick;
            g_wrap = e.sel ? b_wrap : a_wrap;
            g_done = e.sel ? b_done : a_done;
            g_err  = e.sel ? b_err  : a_err;
            chk($sformatf("vec%0d bcd", i), 32'(g_bcd), 32'(e.exp_bcd));
            chk($sformatf("vec%0d seg", i), 32'(g_seg), 32'(exp_seg(e.exp_bcd, !e.sel)));
            chk($sformatf("vec%0d tick", i), 32'(g_tick), 32'(!e.ld));
            chk($sformatf("vec%0d wrap", i), 32'(g_wrap), 32'(e.exp_wrap));
            chk($sformatf("vec%0d done", i), 32'(g_done), 32'(e.exp_done));
            chk($sformatf("vec%0d load_err", i), 32'(g_err), 32'(e.exp_err));
        end

        // Count down 01:00 to 00:00; done only on the last step
        a_up = 1'b0;
        load_a(16'h0100);
        chk("dn load", 32'(a_bcd), 32'h0100);
        for (int unsigned i = 1; i <= 60; i++) begin
            wait_evt(1'b0, n);
            chk($sformatf("dn%0d bcd", i), 32'(a_bcd), 32'(to_bcd(60 - i)));
            chk($sformatf("dn%0d done", i), 32'(a_done), 32'(i == 60));
        end

        // Halted: no steps in either direction until a load
        any = 1'b0;
        repeat (12) begin
            tick_clk();
            any |= a_tick | a_done | a_wrap;
        end
        chk("halt dn evt", 32'(any), 32'd0);
        a_up = 1'b1;
        any = 1'b0;
        repeat (12) begin
            tick_clk();
            any |= a_tick | a_done | a_wrap;
        end
        chk("halt up evt", 32'(any), 32'd0);
        chk("halt bcd", 32'(a_bcd), 32'h0000);
        load_a(16'h0005);
        chk("restart load", 32'(a_bcd), 32'h0005);
        wait_evt(1'b0, n);
        chk("restart gap", 32'(n), 32'd4);
        chk("restart bcd", 32'(a_bcd), 32'h0006);

        // Down step from a loaded 00:00: stays, done, then halts
        a_up = 1'b0;
        load_a(16'h0000);
        wait_evt(1'b0, n);
        chk("zero done", 32'(a_done), 32'd1);
        chk("zero bcd", 32'(a_bcd), 32'h0000);
        any = 1'b0;
        repeat (8) begin
            tick_clk();
            any |= a_tick | a_done;
        end
        chk("zero halt", 32'(any), 32'd0);

        // Load coincident with a step: load wins, step is lost
        a_up = 1'b1;
        load_a(16'h0005);
        wait_evt(1'b0, n);
        chk("coin pre", 32'(a_bcd), 32'h0006);
        repeat (3) tick_clk();
        load_a(16'h0123);
        chk("coin bcd", 32'(a_bcd), 32'h0123);
        chk("coin tick", 32'(a_tick), 32'd0);
        wait_evt(1'b0, n);
        chk("coin gap", 32'(n), 32'd4);
        chk("coin next", 32'(a_bcd), 32'h0124);

        // Asynchronous clear between clock edges
        tick_clk();
        #2 rst_n = 1'b0;
        #1;
        chk("arst a_bcd", 32'(a_bcd), 32'h0000);
        chk("arst a_seg", 32'(a_seg), 32'(exp_seg(16'h0000, 1'b1)));
        chk("arst a_segmt", 32'(a_seg[27:21]), 32'h7F);
        chk("arst b_bcd", 32'(b_bcd), 32'h0000);
        tick_clk();
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
